// File: rtl/riscv_ctrl_pkg.sv
// Shared constants and types for the multicycle RISC-V sequencer.
// Opcodes, funct fields, ALU codes, FSM encoding and instruction classes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_W   = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE
  } cls_t;

  typedef struct packed {
    cls_t       cls;
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic       wb_sel_mem;
    logic       legal;
  } dec_t;

  function automatic logic writes_rd(cls_t c);
    return (c == CLS_R) || (c == CLS_I) || (c == CLS_LOAD);
  endfunction

endpackage

// File: rtl/riscv_seq_ctrl_if.sv
// Control bundle between the sequencer and the datapath.
// master: sequencer side; slave: datapath side.
interface riscv_seq_ctrl_if #(
  parameter int ALU_OP_W = 4
);
  logic [31:0]         instruct;
  logic                last_instr_flag;
  logic                ir_load;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic [4:0]          rd;
  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_src_imm;
  logic                wb_sel_mem;
  logic                mem_read;
  logic                mem_write;
  logic                regenb;
  logic                pcnext;
  logic                finish_flag;
  logic                illegal;
  logic [2:0]          state_o;

  modport master (
    input  instruct, last_instr_flag,
    output ir_load, rs1, rs2, rd, alu_op,
    output alu_src_imm, wb_sel_mem,
    output mem_read, mem_write, regenb,
    output pcnext, finish_flag, illegal,
    output state_o
  );

  modport slave (
    output instruct, last_instr_flag,
    input  ir_load, rs1, rs2, rd, alu_op,
    input  alu_src_imm, wb_sel_mem,
    input  mem_read, mem_write, regenb,
    input  pcnext, finish_flag, illegal,
    input  state_o
  );
endinterface

// File: rtl/riscv_ctrl_decode.sv
// Combinational instruction decoder: opcode/funct fields to
// class, ALU operation, operand/writeback selects and legality.
module riscv_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output dec_t       dec
);

  logic r, i, is_and, is_or, is_add, is_sub;
  logic is_ld, is_st, arith;

  assign r      = opcode == OP_R;
  assign i      = opcode == OP_I;
  assign is_and = (r || i) && funct3 == F3_AND;
  assign is_or  = (r || i) && funct3 == F3_OR;
  assign is_add = funct3 == F3_ADD &&
                  (i || (r && funct7 == F7_BASE));
  assign is_sub = r && funct3 == F3_ADD &&
                  funct7 == F7_ALT;
  assign is_ld  = opcode == OP_LOAD && funct3 == F3_W;
  assign is_st  = opcode == OP_STORE && funct3 == F3_W;
  assign arith  = is_and || is_or || is_add || is_sub;

  always_comb begin
    dec = '{cls: CLS_NOP, alu_op: ALU_AND,
            alu_src_imm: 1'b0, wb_sel_mem: 1'b0,
            legal: 1'b0};
    unique case (1'b1)
      is_and:         dec.alu_op = ALU_AND;
      is_or:          dec.alu_op = ALU_OR;
      is_add:         dec.alu_op = ALU_ADD;
      is_sub:         dec.alu_op = ALU_SUB;
      is_ld, is_st:   dec.alu_op = ALU_ADD;
      default:        dec.alu_op = ALU_AND;
    endcase
    unique case (1'b1)
      arith && r: dec.cls = CLS_R;
      arith && i: dec.cls = CLS_I;
      is_ld:      dec.cls = CLS_LOAD;
      is_st:      dec.cls = CLS_STORE;
      default:    dec.cls = CLS_NOP;
    endcase
    dec.alu_src_imm = (arith && i) || is_ld || is_st;
    dec.wb_sel_mem  = is_ld;
    dec.legal       = arith || is_ld || is_st;
  end

endmodule

// File: rtl/riscv_seq_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with registered strobes.
// RISCV_SEQ_ILLEGAL_TRAP_EN: unsupported encodings trap to HALT.
module riscv_seq_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_LAT  = 1,
  parameter int ALU_OP_W = 4
) (
  input logic              clock,
  input logic              rst,
  riscv_seq_ctrl_if.master bus
);

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  logic [2:0]          state;
  logic [31:0]         ir;
  cls_t                cls;
  logic [2:0]          cnt;
  logic                ir_load, mem_read, mem_write;
  logic                regenb, pcnext, finish;
  logic [4:0]          rs1, rs2, rd;
  logic [ALU_OP_W-1:0] alu_op;
  logic                src_imm, wb_mem;
  dec_t                dec;

  riscv_ctrl_decode u_dec (
    .opcode (ir[6:0]),
    .funct3 (ir[14:12]),
    .funct7 (ir[31:25]),
    .dec    (dec)
  );

`ifdef RISCV_SEQ_ILLEGAL_TRAP_EN
  logic illegal_q;
`else
  logic unused_legal;
  assign unused_legal = dec.legal;
`endif

  // Strobes are registered, so each one appears the cycle after the
  // state that requests it.
  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= S_FETCH;
      ir        <= '0;
      cls       <= CLS_NOP;
      cnt       <= '0;
      ir_load   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      regenb    <= 1'b0;
      pcnext    <= 1'b0;
      finish    <= 1'b0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      alu_op    <= '0;
      src_imm   <= 1'b0;
      wb_mem    <= 1'b0;
`ifdef RISCV_SEQ_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      ir_load   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      regenb    <= 1'b0;
      pcnext    <= 1'b0;
      unique case (state)
        S_FETCH: begin
          if (bus.last_instr_flag) begin
            state  <= S_HALT;
            finish <= 1'b1;
          end else begin
            ir      <= bus.instruct;
            ir_load <= 1'b1;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          rs1     <= ir[19:15];
          rs2     <= ir[24:20];
          rd      <= ir[11:7];
          alu_op  <= ALU_OP_W'(dec.alu_op);
          src_imm <= dec.alu_src_imm;
          wb_mem  <= dec.wb_sel_mem;
          cls     <= dec.cls;
          state   <= S_EXEC;
`ifdef RISCV_SEQ_ILLEGAL_TRAP_EN
          if (!dec.legal) begin
            state     <= S_HALT;
            finish    <= 1'b1;
            illegal_q <= 1'b1;
          end
`endif
        end
        S_EXEC: begin
          if (cls == CLS_LOAD || cls == CLS_STORE) begin
            state <= S_MEM;
            cnt   <= CNT_INIT;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          mem_read  <= cls == CLS_LOAD;
          mem_write <= cls == CLS_STORE;
          if (cnt == 3'd0) state <= S_WB;
          else             cnt   <= cnt - 3'd1;
        end
        S_WB: begin
          pcnext <= 1'b1;
          regenb <= writes_rd(cls) && rd != 5'd0;
          state  <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  assign bus.ir_load     = ir_load;
  assign bus.rs1         = rs1;
  assign bus.rs2         = rs2;
  assign bus.rd          = rd;
  assign bus.alu_op      = alu_op;
  assign bus.alu_src_imm = src_imm;
  assign bus.wb_sel_mem  = wb_mem;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.regenb      = regenb;
  assign bus.pcnext      = pcnext;
  assign bus.finish_flag = finish;
  assign bus.state_o     = state;
`ifdef RISCV_SEQ_ILLEGAL_TRAP_EN
  assign bus.illegal     = illegal_q;
`else
  assign bus.illegal     = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_seq_ctrl.sv
// Self-checking bench for riscv_seq_ctrl: directed and random
// instruction streams against a cycle-count reference model.
module tb_riscv_seq_ctrl;

  localparam int ML = 2;

  logic clock = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  riscv_seq_ctrl_if #(.ALU_OP_W(4)) bus ();

  riscv_seq_ctrl #(.MEM_LAT(ML), .ALU_OP_W(4)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // class: 0=R 1=I 2=LW 3=SW 4=NOP
  function automatic void model(input logic [31:0] ins,
                                output int cls,
                                output logic [3:0] op,
                                output logic imm,
                                output logic wbm);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    cls = 4; op = 4'd0; imm = 1'b0; wbm = 1'b0;
    if (opc == 7'h33) begin
      if (f3 == 3'b111) begin cls = 0; op = 4'd0; end
      else if (f3 == 3'b110) begin cls = 0; op = 4'd1; end
      else if (f3 == 3'b000 && f7 == 7'h00) begin cls = 0; op = 4'd2; end
      else if (f3 == 3'b000 && f7 == 7'h20) begin cls = 0; op = 4'd6; end
    end else if (opc == 7'h13) begin
      if (f3 == 3'b111) begin cls = 1; op = 4'd0; imm = 1'b1; end
      else if (f3 == 3'b110) begin cls = 1; op = 4'd1; imm = 1'b1; end
      else if (f3 == 3'b000) begin cls = 1; op = 4'd2; imm = 1'b1; end
    end else if (opc == 7'h03 && f3 == 3'b010) begin
      cls = 2; op = 4'd2; imm = 1'b1; wbm = 1'b1;
    end else if (opc == 7'h23 && f3 == 3'b010) begin
      cls = 3; op = 4'd2; imm = 1'b1;
    end
  endfunction

  function automatic logic [31:0] gen(input int c);
    logic [31:0] w;
    logic [2:0]  f3s [3];
    w = $urandom;
    f3s[0] = 3'b111; f3s[1] = 3'b110; f3s[2] = 3'b000;
    case (c)
      0: begin
        w[6:0]   = 7'h33;
        w[14:12] = f3s[$urandom_range(0, 2)];
        w[31:25] = (w[14:12] == 3'b000 && $urandom_range(0, 1) == 1)
                   ? 7'h20 : 7'h00;
      end
      1: begin
        w[6:0]   = 7'h13;
        w[14:12] = f3s[$urandom_range(0, 2)];
      end
      2: begin w[6:0] = 7'h03; w[14:12] = 3'b010; end
      3: begin w[6:0] = 7'h23; w[14:12] = 3'b010; end
      default: begin
        case ($urandom_range(0, 3))
          0: w[6:0] = 7'h7F;
          1: begin w[6:0] = 7'h33; w[14:12] = 3'b001; end
          2: begin w[6:0] = 7'h33; w[14:12] = 3'b000; w[31:25] = 7'h01; end
          default: begin w[6:0] = 7'h03; w[14:12] = 3'b000; end
        endcase
      end
    endcase
    return w;
  endfunction

  // Call in a FETCH cycle; returns in the following FETCH cycle.
  task automatic run_instr(input logic [31:0] ins);
    int         cls, lat;
    logic [3:0] op;
    logic       imm, wbm, wr, mem;
    logic [4:0] exp_s, got_s;
    model(ins, cls, op, imm, wbm);
    mem = (cls == 2 || cls == 3);
    lat = mem ? 4 + ML : 4;
    wr  = (cls <= 2) && ins[11:7] != 5'd0;
    bus.instruct        = ins;
    bus.last_instr_flag = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clock); #1;
      exp_s = {k == 1,
               cls == 2 && k >= 4 && k <= 3 + ML,
               cls == 3 && k >= 4 && k <= 3 + ML,
               k == lat && wr,
               k == lat};
      got_s = {bus.ir_load, bus.mem_read, bus.mem_write,
               bus.regenb, bus.pcnext};
      total++;
      if (got_s !== exp_s)
        $display("FAIL strobes ins=%h k=%0d got=%b exp=%b",
                 ins, k, got_s, exp_s);
      else passed++;
      if (k >= 2) begin
        total++;
        if ({bus.rs1, bus.rs2, bus.rd} !==
            {ins[19:15], ins[24:20], ins[11:7]})
          $display("FAIL regs ins=%h k=%0d got=%h/%h/%h",
                   ins, k, bus.rs1, bus.rs2, bus.rd);
        else passed++;
        if (cls != 4) begin
          total++;
          if ({bus.alu_op, bus.alu_src_imm, bus.wb_sel_mem} !==
              {op, imm, wbm})
            $display("FAIL selects ins=%h k=%0d got=%h,%b,%b exp=%h,%b,%b",
                     ins, k, bus.alu_op, bus.alu_src_imm,
                     bus.wb_sel_mem, op, imm, wbm);
          else passed++;
        end
      end
      if (k == lat) begin
        total++;
        if ({bus.state_o, bus.finish_flag, bus.illegal} !== 5'b0)
          $display("FAIL end_state ins=%h got=%0d,%b,%b exp=0,0,0",
                   ins, bus.state_o, bus.finish_flag, bus.illegal);
        else passed++;
      end
      bus.last_instr_flag = (k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k >= 2 && k < lat) bus.instruct = $urandom;
    end
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if ({bus.ir_load, bus.rs1, bus.rs2, bus.rd, bus.alu_op,
         bus.alu_src_imm, bus.wb_sel_mem, bus.mem_read,
         bus.mem_write, bus.regenb, bus.pcnext, bus.finish_flag,
         bus.illegal, bus.state_o} !== 31'b0)
      $display("FAIL %s outputs not zero: st=%0d ir=%b rd=%0d op=%h mr=%b fin=%b",
               tag, bus.state_o, bus.ir_load, bus.rd, bus.alu_op,
               bus.mem_read, bus.finish_flag);
    else passed++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.instruct        = 32'h002081B3;
    bus.last_instr_flag = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.instruct        = 32'h002081B3;
    bus.last_instr_flag = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      check_all_zero("reset_hold");
    end
    do_reset();
  endtask

  task automatic test_add();
    run_instr(32'h002081B3);
  endtask

  task automatic test_sub_ori();
    run_instr(32'h407302B3);
    run_instr(32'h00F26213);
  endtask

  task automatic test_lw();
    run_instr(32'h00402403);
  endtask

  task automatic test_sw();
    run_instr(32'h00802423);
  endtask

  task automatic test_x0();
    run_instr(32'h00500013);
  endtask

  task automatic test_nop();
`ifdef RISCV_SEQ_ILLEGAL_TRAP_EN
    bus.instruct        = 32'h0000007F;
    bus.last_instr_flag = 1'b0;
    @(posedge clock); #1;
    total++;
    if (bus.ir_load !== 1'b1)
      $display("FAIL trap_ir_load got=%b exp=1", bus.ir_load);
    else passed++;
    @(posedge clock); #1;
    total++;
    if ({bus.state_o, bus.illegal, bus.finish_flag} !== {3'd5, 2'b11})
      $display("FAIL trap got=%0d,%b,%b exp=5,1,1",
               bus.state_o, bus.illegal, bus.finish_flag);
    else passed++;
    repeat (8) begin
      @(posedge clock); #1;
      total++;
      if ({bus.pcnext, bus.regenb, bus.mem_read, bus.mem_write} !== 4'b0)
        $display("FAIL trap_strobes got=%b%b%b%b exp=0000", bus.pcnext,
                 bus.regenb, bus.mem_read, bus.mem_write);
      else passed++;
    end
    do_reset();
`else
    run_instr(32'h0000007F);
    run_instr(gen(4));
    run_instr(gen(4));
`endif
  endtask

  task automatic test_random();
`ifdef RISCV_SEQ_ILLEGAL_TRAP_EN
    for (int n = 0; n < 40; n++) run_instr(gen($urandom_range(0, 3)));
`else
    for (int n = 0; n < 40; n++) run_instr(gen($urandom_range(0, 4)));
`endif
  endtask

  task automatic test_reset_mid_mem();
    bus.instruct        = 32'h00402403;
    bus.last_instr_flag = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (bus.state_o !== 3'd3)
      $display("FAIL mid_mem_state got=%0d exp=3", bus.state_o);
    else passed++;
    rst = 1'b1;
    @(posedge clock); #1;
    check_all_zero("reset_mid_mem");
    rst = 1'b0;
    run_instr(32'h00802423);
  endtask

  task automatic test_halt();
    bus.last_instr_flag = 1'b1;
    bus.instruct        = 32'h002081B3;
    @(posedge clock); #1;
    total++;
    if ({bus.state_o, bus.finish_flag, bus.ir_load} !== {3'd5, 2'b10})
      $display("FAIL halt_entry got=%0d,%b,%b exp=5,1,0",
               bus.state_o, bus.finish_flag, bus.ir_load);
    else passed++;
    for (int n = 0; n < 20; n++) begin
      bus.last_instr_flag = 1'($urandom_range(0, 1));
      bus.instruct        = $urandom;
      @(posedge clock); #1;
      total++;
      if ({bus.state_o, bus.finish_flag, bus.ir_load, bus.mem_read,
           bus.mem_write, bus.regenb, bus.pcnext} !== {3'd5, 6'b100000})
        $display("FAIL halt_hold n=%0d got=%0d,%b,%b%b%b%b%b exp=5,1,00000",
                 n, bus.state_o, bus.finish_flag, bus.ir_load,
                 bus.mem_read, bus.mem_write, bus.regenb, bus.pcnext);
      else passed++;
    end
    do_reset();
    run_instr(32'h002081B3);
  endtask

  initial begin
    rst                 = 1'b1;
    bus.instruct        = '0;
    bus.last_instr_flag = 1'b0;
    test_reset();
    test_add();
    test_sub_ori();
    test_lw();
    test_sw();
    test_x0();
    test_nop();
    test_random();
    test_reset_mid_mem();
    test_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
